// File: rtl/three_sort_pkg.sv
// Shared constants and the in-flight tag type for the three_sort arbiter slice.
package three_sort_pkg;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_W        = 8;
    localparam int DEF_SORT_LAT = 2;
    // Wide enough for the largest supported requester count (8).
    localparam int ID_W         = 3;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] idx_s;
    logic          found_s;
    logic          hit_s;

    // Scan upward from ptr; the first valid requester takes the grant.
    always_comb begin
        gnt     = '0;
        found_s = 1'b0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx_s      = PW'((int'(ptr) + k) % N);
            hit_s      = !found_s && req[idx_s];
            gnt[idx_s] = hit_s;
            found_s    = found_s | hit_s;
        end
    end

endmodule

// File: rtl/three_sort.sv
// Two-stage unsigned three-operand sorter: L_out >= M_out >= S_out, two cycles after A/B/C_in.
module three_sort
    import three_sort_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] A_in,
    input  logic [W-1:0] B_in,
    input  logic [W-1:0] C_in,
    output logic [W-1:0] L_out,
    output logic [W-1:0] M_out,
    output logic [W-1:0] S_out
);

    logic [W-1:0] hi_q, lo_q, c_q;
    logic [W-1:0] l_q, m_q, s_q;
    logic [W-1:0] l_d, m_d, s_d;

    // Stage 1: order the A/B pair, carry C alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
            c_q  <= '0;
        end else begin
            hi_q <= (A_in >= B_in) ? A_in : B_in;
            lo_q <= (A_in >= B_in) ? B_in : A_in;
            c_q  <= C_in;
        end
    end

    // Stage 2 logic: insert C into the ordered pair.
    always_comb begin
        l_d = hi_q;
        m_d = lo_q;
        s_d = c_q;
        if (c_q >= hi_q) begin
            l_d = c_q;
            m_d = hi_q;
            s_d = lo_q;
        end else if (c_q >= lo_q) begin
            l_d = hi_q;
            m_d = c_q;
            s_d = lo_q;
        end else begin
            l_d = hi_q;
            m_d = lo_q;
            s_d = c_q;
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q <= '0;
            m_q <= '0;
            s_q <= '0;
        end else begin
            l_q <= l_d;
            m_q <= m_d;
            s_q <= s_d;
        end
    end

    assign L_out = l_q;
    assign M_out = m_q;
    assign S_out = s_q;

endmodule

// File: rtl/three_sort_arbiter.sv
// Round-robin sharing of one staged three_sort among NUM_REQ requesters, with tag tracking.
// Optional THREE_SORT_ARB_CHECK_EN adds a sticky order_err output checking result ordering.
module three_sort_arbiter
    import three_sort_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int W        = DEF_W,
    parameter int SORT_LAT = DEF_SORT_LAT
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*W-1:0]             req_a,
    input  logic [NUM_REQ*W-1:0]             req_b,
    input  logic [NUM_REQ*W-1:0]             req_c,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             out_valid,
    output logic [$clog2(NUM_REQ)-1:0]       out_id,
    output logic [W-1:0]                     out_l,
    output logic [W-1:0]                     out_m,
    output logic [W-1:0]                     out_s,
    output logic [$clog2(SORT_LAT+3)-1:0]    inflight
`ifdef THREE_SORT_ARB_CHECK_EN
    ,
    output logic                             order_err
`endif
);

    localparam int OUT_ID_W = $clog2(NUM_REQ);
    localparam int CNT_W    = $clog2(SORT_LAT + 3);

    logic [OUT_ID_W-1:0] ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  gnt_s;
    logic                xfer_s;
    logic [OUT_ID_W-1:0] win_id_s;
    logic [W-1:0]        a_q, b_q, c_q;
    logic [W-1:0]        sort_l_s, sort_m_s, sort_s_s;
    tag_t                tag_d;
    tag_t                tag_q [SORT_LAT+1];
    logic                out_valid_q;
    logic [OUT_ID_W-1:0] out_id_q;
    logic [W-1:0]        out_l_q, out_m_q, out_s_q;
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic                unused_tag_s;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt_s)
    );

    // Grants are suppressed while reset is held so nothing handshakes into a cleared pipe.
    assign req_ready = rst_n ? gnt_s : '0;
    assign xfer_s    = |(req_valid & gnt_s);

    // Encode the one-hot grant into the winner's id.
    always_comb begin
        win_id_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_id_s = win_id_s | (gnt_s[i] ? OUT_ID_W'(i) : '0);
        end
    end

    // Pointer advances past the winner, wrapping at NUM_REQ.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer_s) begin
            if (win_id_s == OUT_ID_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_id_s + OUT_ID_W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    assign tag_d = '{valid: xfer_s, id: ID_W'(win_id_s)};

    // Pointer and issue registers; issue data holds on a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (xfer_s) begin
                a_q <= req_a[int'(win_id_s)*W +: W];
                b_q <= req_b[int'(win_id_s)*W +: W];
                c_q <= req_c[int'(win_id_s)*W +: W];
            end
        end
    end

    three_sort #(.W(W)) u_sort (
        .clk   (clk),
        .rst_n (rst_n),
        .A_in  (a_q),
        .B_in  (b_q),
        .C_in  (c_q),
        .L_out (sort_l_s),
        .M_out (sort_m_s),
        .S_out (sort_s_s)
    );

    // Tag pipeline; stage SORT_LAT lines up with the sorter outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= SORT_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int k = 1; k <= SORT_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // Upper tag id bits are spare when NUM_REQ needs fewer than ID_W bits.
    assign unused_tag_s = ^tag_q[SORT_LAT].id;

    // Output register loads only on a valid tag, otherwise holds the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_l_q     <= '0;
            out_m_q     <= '0;
            out_s_q     <= '0;
        end else begin
            out_valid_q <= tag_q[SORT_LAT].valid;
            if (tag_q[SORT_LAT].valid) begin
                out_id_q <= tag_q[SORT_LAT].id[OUT_ID_W-1:0];
                out_l_q  <= sort_l_s;
                out_m_q  <= sort_m_s;
                out_s_q  <= sort_s_s;
            end
        end
    end

    // In-flight count: +1 on accept, -1 on result, hold when both or neither.
    always_comb begin
        case ({xfer_s, out_valid_q})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // In-flight counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_l     = out_l_q;
    assign out_m     = out_m_q;
    assign out_s     = out_s_q;
    assign inflight  = inflight_q;

`ifdef THREE_SORT_ARB_CHECK_EN
    logic order_err_q;

    // Sticky flag on any presented result that is not descending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            order_err_q <= 1'b0;
        end else begin
            order_err_q <= order_err_q |
                           (out_valid_q && !((out_l_q >= out_m_q) && (out_m_q >= out_s_q)));
        end
    end

    assign order_err = order_err_q;
`endif

endmodule

// File: tb/tb_three_sort_arbiter.sv
// Directed self-checking bench for three_sort_arbiter with hand-computed expectations.
module tb_three_sort_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int W        = 8;
    localparam int SORT_LAT = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*W-1:0] req_a, req_b, req_c;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 out_valid;
    logic [1:0]           out_id;
    logic [W-1:0]         out_l, out_m, out_s;
    logic [2:0]           inflight;
`ifdef THREE_SORT_ARB_CHECK_EN
    logic                 order_err;
`endif

    int checks = 0;
    int errors = 0;

    three_sort_arbiter #(.NUM_REQ(NUM_REQ), .W(W), .SORT_LAT(SORT_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_l     (out_l),
        .out_m     (out_m),
        .out_s     (out_s),
        .inflight  (inflight)
`ifdef THREE_SORT_ARB_CHECK_EN
        ,
        .order_err (order_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_c[i*W +: W] = c;
    endtask

    initial begin
        logic [1:0] wrap_ids [3];
        int         id_e;
        int         exp_infl;
        int         outs;
        wrap_ids = '{2'd3, 2'd0, 2'd3};

        req_a = '0;
        req_b = '0;
        req_c = '0;
        req_valid = 4'b1111;

        // Reset state, with all requests pending
        #12;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_id", 32'(out_id), 32'd0);
        check_val("rst_out_l", 32'(out_l), 32'd0);
        check_val("rst_out_m", 32'(out_m), 32'd0);
        check_val("rst_out_s", 32'(out_s), 32'd0);
        check_val("rst_inflight", 32'(inflight), 32'd0);
        check_val("rst_ready", 32'(req_ready), 32'd0);
        req_valid = 4'b0000;
        step();
        rst_n = 1'b1;

        // Single request from requester 2
        set_ops(2, 8'd5, 8'd200, 8'd17);
        req_valid = 4'b0100;
        #1;
        check_val("single_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'b0000;
        check_val("single_infl1", 32'(inflight), 32'd1);
        check_val("single_early", 32'(out_valid), 32'd0);
        step();
        step();
        check_val("single_early2", 32'(out_valid), 32'd0);
        step();
        check_val("single_valid", 32'(out_valid), 32'd1);
        check_val("single_l", 32'(out_l), 32'd200);
        check_val("single_m", 32'(out_m), 32'd17);
        check_val("single_s", 32'(out_s), 32'd5);
        check_val("single_id", 32'(out_id), 32'd2);
        check_val("single_infl_hold", 32'(inflight), 32'd1);
        step();
        check_val("single_done", 32'(out_valid), 32'd0);
        check_val("single_infl0", 32'(inflight), 32'd0);
        check_val("single_hold_l", 32'(out_l), 32'd200);

        // Pointer wrap: ptr is 3 after serving requester 2
        set_ops(3, 8'd9, 8'd8, 8'd7);
        set_ops(0, 8'd1, 8'd2, 8'd3);
        req_valid = 4'b1000;
        #1;
        check_val("wrap_ready3", 32'(req_ready), 32'b1000);
        step();
        req_valid = 4'b1001;
        #1;
        check_val("wrap_ready0", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b1000;
        #1;
        check_val("wrap_ready3b", 32'(req_ready), 32'b1000);
        step();
        req_valid = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i < 3) begin
                check_val("wrap_valid", 32'(out_valid), 32'd1);
                check_val("wrap_id", 32'(out_id), 32'(wrap_ids[i]));
            end
        end
        check_val("wrap_last_l", 32'(out_l), 32'd9);

        // Full contention for 8 cycles starting from ptr 0
        for (int i = 0; i < NUM_REQ; i++) begin
            set_ops(i, 8'(i*10+1), 8'(i*10+3), 8'(i*10+2));
        end
        outs = 0;
        for (int k = 0; k < 12; k++) begin
            if (k < 8) begin
                req_valid = 4'b1111;
                #1;
                check_val("cont_ready", 32'(req_ready), 32'(1 << (k % 4)));
            end else begin
                req_valid = 4'b0000;
                #1;
                check_val("cont_ready_idle", 32'(req_ready), 32'd0);
            end
            step();
            if (k >= 3 && k <= 10) begin
                id_e = (k - 3) % 4;
                check_val("cont_valid", 32'(out_valid), 32'd1);
                check_val("cont_id", 32'(out_id), 32'(id_e));
                check_val("cont_l", 32'(out_l), 32'(id_e*10+3));
                check_val("cont_m", 32'(out_m), 32'(id_e*10+2));
                check_val("cont_s", 32'(out_s), 32'(id_e*10+1));
            end else begin
                check_val("cont_idle", 32'(out_valid), 32'd0);
            end
            exp_infl = ((k + 1) < 8 ? (k + 1) : 8) - outs;
            check_val("cont_inflight", 32'(inflight), 32'(exp_infl));
            if (k >= 3 && k <= 10) outs++;
        end

        // Ties and equal operands
        set_ops(1, 8'd255, 8'd255, 8'd255);
        req_valid = 4'b0010;
        #1;
        check_val("tie_ready1", 32'(req_ready), 32'b0010);
        step();
        set_ops(3, 8'd0, 8'd0, 8'd1);
        req_valid = 4'b1000;
        #1;
        check_val("tie_ready3", 32'(req_ready), 32'b1000);
        step();
        req_valid = 4'b0000;
        step();
        step();
        check_val("tie1_valid", 32'(out_valid), 32'd1);
        check_val("tie1_id", 32'(out_id), 32'd1);
        check_val("tie1_lms", 32'({out_l, out_m, out_s}), 32'h00FF_FFFF);
        step();
        check_val("tie2_valid", 32'(out_valid), 32'd1);
        check_val("tie2_id", 32'(out_id), 32'd3);
        check_val("tie2_lms", 32'({out_l, out_m, out_s}), 32'h0001_0000);
        step();
        step();

        // Reset mid-flight
        for (int i = 0; i < 3; i++) begin
            set_ops(i, 8'(i+40), 8'(i+60), 8'(i+50));
        end
        req_valid = 4'b0111;
        step();
        step();
        step();
        req_valid = 4'b0000;
        step();
        step();
        #2;
        rst_n = 1'b0;
        req_valid = 4'b1111;
        #1;
        check_val("mid_rst_valid", 32'(out_valid), 32'd0);
        check_val("mid_rst_l", 32'(out_l), 32'd0);
        check_val("mid_rst_id", 32'(out_id), 32'd0);
        check_val("mid_rst_infl", 32'(inflight), 32'd0);
        check_val("mid_rst_ready", 32'(req_ready), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        req_valid = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            step();
            check_val("post_rst_stale", 32'(out_valid), 32'd0);
        end
        req_valid = 4'b1111;
        #1;
        check_val("post_rst_ptr", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0000;
        for (int i = 0; i < 5; i++) step();

`ifdef THREE_SORT_ARB_CHECK_EN
        check_val("order_err_clean", 32'(order_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/three_sort_arbiter.md
# three_sort_arbiter

Shares one staged `three_sort` instance between `NUM_REQ` requesters. Each requester presents a triple of unsigned operands with a valid/ready handshake. A round-robin arbiter issues at most one triple per cycle into the sorter. A tag pipeline tracks which requester owns each in-flight result, and the arbiter returns the sorted triple (largest, middle, smallest) with the owner's ID. The block sits between the packet-level consumers and the shared sorter datapath.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `W`, 8: operand width in bits.
- `SORT_LAT`, 2: latency in clock cycles of the instantiated staged `three_sort`. Must match its stage count.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester valid.
- `req_a`, `req_b`, `req_c` in NUM_REQ*W: packed operands; requester i occupies bits [i*W +: W].
- `req_ready` out NUM_REQ: one-hot grant, or all zero.
- `out_valid` out 1: result strobe, asserted for one cycle per result.
- `out_id` out clog2(NUM_REQ): owner of the current result.
- `out_l`, `out_m`, `out_s` out W: sorted result, with out_l ≥ out_m ≥ out_s.
- `inflight` out clog2(SORT_LAT+3): number of accepted triples not yet returned.
- `order_err` out 1: present only with `THREE_SORT_ARB_CHECK_EN`.

## Operation
- **Arbitration**
  - `req_ready` is combinational from `req_valid` and the round-robin pointer `ptr`.
  - The grant goes to the first valid requester found searching upward from `ptr`, wrapping around.
  - `req_ready` is zero when no request is valid.
  - There is no output backpressure, so a grant is available every cycle.
- **Handshake**
  - A transfer occurs when `req_valid[i] && req_ready[i]`.
  - A requester may hold `req_valid` across cycles. Operands must remain stable until the transfer.
  - Deasserting `req_valid` before the grant is allowed and discards the request.
- **Pointer update**
  - On a transfer from requester i, `ptr` becomes (i+1) mod NUM_REQ.
  - With no transfer, `ptr` holds.
- **Issue register**
  - On a transfer, the winner's a/b/c are captured into the issue registers that drive the sorter's A_in/B_in/C_in.
  - In the same cycle, `{1'b1, id}` enters the tag pipeline. Without a transfer, a bubble (`valid=0`) enters.
  - The issue data registers hold their value on a bubble.
- **Tag pipeline**
  - `SORT_LAT+1` stages, aligned to the sorter outputs.
- **Output register**
  - When the last tag stage is valid, `out_l/m/s` load from the sorter's L_out/M_out/S_out and `out_id` loads the tag.
  - `out_valid` follows the tag's valid bit.
  - On a bubble, `out_l/m/s` and `out_id` hold their previous values.
- **In-flight count**
  - `inflight` increments on a transfer and decrements when `out_valid` is asserted.
  - When both happen in the same cycle, it holds.
  - Its maximum is SORT_LAT+2; it never overflows because at most one triple is issued per cycle.
- **Arithmetic**
  - Comparisons are unsigned.
  - Equal operands are legal and pass through unchanged in value.

## Timing
- Latency from transfer edge to `out_valid` is SORT_LAT+2 cycles (4 by default).
- Throughput is one triple per cycle, aggregate across all requesters.
- Reset values:
  - `out_valid`=0, `out_id`=0, `out_l/m/s`=0, `inflight`=0.
  - `ptr`=0, all tag valid bits 0, issue registers 0.
  - `order_err`=0.
- Reset asserted mid-operation:
  - All in-flight results are dropped, and no `out_valid` appears for them after release.
  - `req_ready` is 0 while `rst_n` is low.
- On the first edge after reset release, a valid request can be granted. Requester 0 wins a tie.
- Simultaneous requests from all NUM_REQ requesters are served in strict rotation, one per cycle. Each requester waits at most NUM_REQ-1 cycles.

## Configuration
- `THREE_SORT_ARB_CHECK_EN` defined:
  - Adds the `order_err` output.
  - `order_err` is sticky and set when `out_valid` is asserted and !(out_l ≥ out_m ≥ out_s).
  - It is cleared only by reset.
- Not defined: no `order_err` port and no checker logic. All other behaviour is identical.

## Structure
- Shared package `three_sort_pkg` holds:
  - Default `W` and `SORT_LAT` constants.
  - The tag struct typedef `{logic valid; logic [ID_W-1:0] id;}`.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs `req[N-1:0]` and `ptr`.
  - Output: one-hot `gnt`, combinational.
- The top level instantiates `rr_arbiter` and the existing staged `three_sort`.

## Test plan
- **Single request:** requester 2 presents a=5, b=200, c=17 for one cycle.
  - Expect `out_valid` 4 cycles later with out_l=200, out_m=17, out_s=5, out_id=2.
  - `inflight` goes 1 then back to 0.
- **Full contention:** all four requesters hold valid for 8 cycles.
  - Grant order is 0,1,2,3,0,1,2,3.
  - Results return in the same order, with `out_valid` high for 8 consecutive cycles.
- **Ties:** requester 1 sends a=b=c=255, then requester 3 sends a=0, b=0, c=1.
  - Expect (255,255,255) with id 1, then (1,0,0) with id 3.
- **Reset mid-flight:** issue three triples, then pull `rst_n` low asynchronously 2 cycles later.
  - All outputs go to 0 immediately, no stale `out_valid` appears after release, and `ptr` restarts at 0.
- **Pointer wrap:** only requester 3 is active, then requesters 0 and 3 together.
  - Grant goes to 0 first (ptr=0 after serving 3), then to 3.
- **Checker:** with `THREE_SORT_ARB_CHECK_EN` defined, force a miswired sorter stub that swaps the outputs.
  - `order_err` rises on the first `out_valid` and stays high.
